// File: rtl/reset_seq.sv
// reset_seq: stretched reset generator with ordered, gapped release of NDOM domains
module reset_seq #(
    parameter int STRETCH = 16,
    parameter int GAP     = 4,
    parameter int NDOM    = 3,
    parameter int WDG_W   = 16,
    parameter int WDG_LIM = 1000
) (
    input  logic            clk_A,
    input  logic            rst_in,
    input  logic            sw_req,
    input  logic            wdg_en,
    input  logic            wdg_kick,
    output logic [NDOM-1:0] nrst_out,
    output logic            busy,
    output logic            done,
    output logic [1:0]      cause
);
    localparam int SW = STRETCH > 1 ? $clog2(STRETCH) : 1;
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDG = 2'b10;

    typedef enum logic [1:0] {ASSERT, RELEASE, IDLE} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    str_q, str_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WDG_W-1:0] wdg_q, wdg_d;
    logic [NDOM-1:0]  nrst_q, nrst_d, nrst_shift;
    logic [1:0]       cause_q, cause_d;
    logic             busy_q, done_q, timeout;

    // Next release pattern: one more low-order bit set, so bits only ever rise in index order
    assign nrst_shift = (nrst_q << 1) | NDOM'(1);
    // A kick in the same cycle masks the timeout
    assign timeout = (state_q == IDLE) && wdg_en && !wdg_kick && (wdg_q == WDG_W'(WDG_LIM - 1));

    // Next-state: stretch, gapped release, watchdog count, then trigger overrides (software beats watchdog)
    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        gap_d   = gap_q;
        nrst_d  = nrst_q;
        cause_d = cause_q;
        wdg_d   = '0;
        case (state_q)
            ASSERT: begin
                nrst_d = '0;
                if (str_q == SW'(STRETCH - 1)) begin
                    nrst_d  = NDOM'(1);
                    gap_d   = '0;
                    state_d = (NDOM == 1) ? IDLE : RELEASE;
                end else begin
                    str_d = str_q + 1'b1;
                end
            end
            RELEASE: begin
                if (gap_q == GW'(GAP - 1)) begin
                    nrst_d  = nrst_shift;
                    gap_d   = '0;
                    state_d = (&nrst_shift) ? IDLE : RELEASE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            IDLE: begin
                nrst_d = '1;
                wdg_d  = (!wdg_en || wdg_kick) ? '0 : wdg_q + 1'b1;
            end
            default: state_d = ASSERT;
        endcase
        if (sw_req || timeout) begin
            state_d = ASSERT;
            str_d   = '0;
            gap_d   = '0;
            nrst_d  = '0;
            wdg_d   = '0;
            cause_d = sw_req ? CAUSE_SW : CAUSE_WDG;
        end
    end

    // State and registered outputs; rst_in overrides everything and records a power-on cause
    always_ff @(posedge clk_A) begin
        if (rst_in) begin
            state_q <= ASSERT;
            str_q   <= '0;
            gap_q   <= '0;
            nrst_q  <= '0;
            wdg_q   <= '0;
            cause_q <= CAUSE_POR;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            gap_q   <= gap_d;
            nrst_q  <= nrst_d;
            wdg_q   <= wdg_d;
            cause_q <= cause_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == IDLE;
        end
    end

    assign nrst_out = nrst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cause    = cause_q;
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed checks of release timing, restarts, watchdog and collisions
module tb_reset_seq;
    logic clk_A = 1'b0;
    always #5 clk_A = ~clk_A;

    logic       rst_in = 1'b1, sw_req = 1'b0, wdg_en = 1'b0, wdg_kick = 1'b0;
    logic [2:0] nrst_out;
    logic       busy, done;
    logic [1:0] cause;

    logic       rst2 = 1'b1, sw2 = 1'b0;
    logic [0:0] nrst2;
    logic       busy2, done2;
    logic [1:0] cause2;

    int n_run = 0, n_fail = 0;

    reset_seq #(.WDG_LIM(100)) dut (
        .clk_A(clk_A), .rst_in(rst_in), .sw_req(sw_req), .wdg_en(wdg_en), .wdg_kick(wdg_kick),
        .nrst_out(nrst_out), .busy(busy), .done(done), .cause(cause)
    );

    reset_seq #(.NDOM(1), .STRETCH(1)) dut1 (
        .clk_A(clk_A), .rst_in(rst2), .sw_req(sw2), .wdg_en(1'b0), .wdg_kick(1'b0),
        .nrst_out(nrst2), .busy(busy2), .done(done2), .cause(cause2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_A);
        #1;
    endtask

    initial begin
        int bad;
        tick(3);
        check("rst_nrst", nrst_out, 3'b000);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_cause", cause, 2'b00);
        check("rst_nrst1", nrst2, 0);
        rst_in = 1'b0;
        rst2   = 1'b0;
        tick(1);
        check("n1_por_nrst", nrst2, 1);
        check("n1_por_done", done2, 1);
        tick(14);
        check("por_e15", nrst_out, 3'b000);
        sw2 = 1'b1;
        tick(1);
        sw2 = 1'b0;
        check("por_e16", nrst_out, 3'b001);
        check("n1_sw_nrst", nrst2, 0);
        check("n1_sw_busy", busy2, 1);
        check("n1_sw_done", done2, 0);
        check("n1_sw_cause", cause2, 2'b01);
        tick(1);
        check("n1_s1_nrst", nrst2, 1);
        check("n1_s1_done", done2, 1);
        check("n1_s1_busy", busy2, 0);
        tick(2);
        check("por_e19", nrst_out, 3'b001);
        tick(1);
        check("por_e20", nrst_out, 3'b011);
        tick(3);
        check("por_e23_nrst", nrst_out, 3'b011);
        check("por_e23_done", done, 0);
        tick(1);
        check("por_e24_nrst", nrst_out, 3'b111);
        check("por_e24_done", done, 1);
        check("por_e24_busy", busy, 0);
        check("por_cause", cause, 2'b00);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("sw_s0_nrst", nrst_out, 3'b000);
        check("sw_s0_cause", cause, 2'b01);
        check("sw_s0_busy", busy, 1);
        check("sw_s0_done", done, 0);
        tick(15);
        check("sw_s15", nrst_out, 3'b000);
        tick(1);
        check("sw_s16", nrst_out, 3'b001);
        tick(8);
        check("sw_s24_nrst", nrst_out, 3'b111);
        check("sw_s24_done", done, 1);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        tick(20);
        check("mid_e20", nrst_out, 3'b011);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("mid_e21_nrst", nrst_out, 3'b000);
        check("mid_e21_busy", busy, 1);
        tick(15);
        check("mid_e36", nrst_out, 3'b000);
        tick(1);
        check("mid_e37", nrst_out, 3'b001);
        tick(8);
        check("mid_e45_nrst", nrst_out, 3'b111);
        check("mid_e45_done", done, 1);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        tick(17);
        rst_in = 1'b1;
        tick(1);
        check("rmid_nrst", nrst_out, 3'b000);
        check("rmid_cause", cause, 2'b00);
        rst_in = 1'b0;
        tick(15);
        check("rmid_e15", nrst_out, 3'b000);
        tick(1);
        check("rmid_e16", nrst_out, 3'b001);
        tick(8);
        check("rmid_e24", nrst_out, 3'b111);
        check("rmid_cause2", cause, 2'b00);
        wdg_en = 1'b1;
        tick(99);
        check("wdg_99_nrst", nrst_out, 3'b111);
        check("wdg_99_busy", busy, 0);
        tick(1);
        check("wdg_100_nrst", nrst_out, 3'b000);
        check("wdg_100_cause", cause, 2'b10);
        tick(24);
        check("wdg_rel", nrst_out, 3'b111);
        check("wdg_cause_hold", cause, 2'b10);
        tick(99);
        wdg_kick = 1'b1;
        tick(1);
        wdg_kick = 1'b0;
        check("kick_col_nrst", nrst_out, 3'b111);
        check("kick_col_busy", busy, 0);
        tick(99);
        check("kick_clr_99", nrst_out, 3'b111);
        tick(1);
        check("kick_clr_100", nrst_out, 3'b000);
        tick(24);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            wdg_kick = (i % 50 == 49);
            tick(1);
            if (nrst_out !== 3'b111) bad++;
        end
        wdg_kick = 1'b0;
        check("kick_hold", bad, 0);
        wdg_en = 1'b0;
        tick(1);
        wdg_en = 1'b1;
        tick(99);
        check("col_pre", nrst_out, 3'b111);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("col_nrst", nrst_out, 3'b000);
        check("col_cause", cause, 2'b01);
        tick(24);
        check("col_rel", nrst_out, 3'b111);
        check("col_cause_hold", cause, 2'b01);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
